// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Two-state instruction fetch unit with IR, PC and next-PC logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        advance,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Branch,
    input  logic        Bneq,
    input  logic        Jr,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        align_err
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_align_err;
    logic [31:0] w_seq_pc;
    logic [31:0] w_br_off;
    logic        w_taken;
    logic [31:0] w_next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        case (r_state)
            FETCH: begin
                // Request is masked while reset is held so memory sees no read.
                imem_req = rst_n;
                if (imem_ready) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (advance) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    assign w_seq_pc = r_pc + 32'd4;
    assign w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_taken  = (Branch & zero) | (Bneq & ~zero);

    always_comb begin
        w_next_pc = w_seq_pc;
        if (Jr) begin
            w_next_pc = {rs_data[31:2], 2'b00};
        end else if (Jmp || Jal) begin
            w_next_pc = {w_seq_pc[31:28], r_ir[25:0], 2'b00};
        end else if (w_taken) begin
            w_next_pc = w_seq_pc + w_br_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_ir        <= 32'h0000_0000;
            r_align_err <= 1'b0;
        end else begin
            if ((r_state == FETCH) && imem_ready) begin
                r_ir <= imem_rdata;
            end
            // Flow inputs only matter in the HOLD cycle that retires the IR.
            if ((r_state == HOLD) && advance) begin
                r_pc <= w_next_pc;
                if (Jr && (rs_data[1:0] != 2'b00)) begin
                    r_align_err <= 1'b1;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = w_seq_pc;
    assign instr     = r_ir;
    assign opcode    = r_ir[31:26];
    assign align_err = r_align_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch with a behavioural PC model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        advance;
    logic        Jmp, Jal, Branch, Bneq, Jr, zero;
    logic [31:0] rs_data;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        align_err;

    instr_fetch #(.RESET_PC(C_RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .advance    (advance),
        .Jmp        (Jmp),
        .Jal        (Jal),
        .Branch     (Branch),
        .Bneq       (Bneq),
        .Jr         (Jr),
        .zero       (zero),
        .rs_data    (rs_data),
        .instr      (instr),
        .opcode     (opcode),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid),
        .align_err  (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        align;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    bit          m_fetching;
    logic [31:0] m_pc;
    logic        m_align;
    bit          prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural next-PC rule, written directly from the ISA semantics.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ir,
                                               input bit jr, input bit jmp, input bit jal,
                                               input bit br, input bit bn, input bit z,
                                               input logic [31:0] rs);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (jr) return rs & 32'hFFFF_FFFC;
        if (jmp || jal) return {seq[31:28], ir[25:0], 2'b00};
        if ((br && z) || (bn && !z)) return seq + 32'($signed(ir[15:0]) * 4);
        return seq;
    endfunction

    task automatic model_reset();
        m_fetching = 1'b1;
        m_pc       = C_RESET_PC;
        m_align    = 1'b0;
        q.delete();
    endtask

    logic [31:0] m_ir;

    // One clock of stimulus; the model advances alongside the DUT inputs.
    task automatic drive(input bit rdy, input logic [31:0] rd, input bit adv,
                         input bit jr, input bit jmp, input bit jal, input bit br,
                         input bit bn, input bit z, input logic [31:0] rs);
        exp_t e;
        @(negedge clk);
        #1;
        imem_ready = rdy; imem_rdata = rd; advance = adv;
        Jr = jr; Jmp = jmp; Jal = jal; Branch = br; Bneq = bn; zero = z; rs_data = rs;
        if (m_fetching) begin
            if (rdy) begin
                m_ir = rd;
                e.pc = m_pc; e.ir = rd; e.align = m_align;
                q.push_back(e);
                m_fetching = 1'b0;
            end
        end else if (adv) begin
            if (jr && (rs[1:0] != 2'b00)) m_align = 1'b1;
            m_pc = model_next(m_pc, m_ir, jr, jmp, jal, br, bn, z, rs);
            m_fetching = 1'b1;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("async_rst_pc", pc, C_RESET_PC);
        check("async_rst_req", {31'd0, imem_req}, 32'd0);
        check("async_rst_align", {31'd0, align_err}, 32'd0);
        model_reset();
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #1;
        check("late_ready_ir", instr, 32'd0);
        imem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    // Monitor: pop an expected instruction each time a new one is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (instr_valid && !prev_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_instr", {31'd0, instr_valid}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("instr", instr, e.ir);
                        check("opcode", {26'd0, opcode}, {26'd0, e.ir[31:26]});
                        check("pc", pc, e.pc);
                        check("pc_plus4", pc_plus4, e.pc + 32'd4);
                        check("align_err", {31'd0, align_err}, {31'd0, e.align});
                    end
                end
                if (m_fetching) begin
                    check("fetch_req", {31'd0, imem_req}, 32'd1);
                    check("fetch_valid", {31'd0, instr_valid}, 32'd0);
                    check("fetch_addr", imem_addr, m_pc);
                end
            end
            prev_valid = instr_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678; advance = 1'b0;
        Jmp = 1'b0; Jal = 1'b0; Branch = 1'b0; Bneq = 1'b0; Jr = 1'b0; zero = 1'b0;
        rs_data = 32'd0;
        model_reset();
        m_ir = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_opcode", {26'd0, opcode}, 32'd0);
        check("rst_pc", pc, C_RESET_PC);
        check("rst_ir", instr, 32'd0);
        check("rst_align", {31'd0, align_err}, 32'd0);
        check("rst_pc_plus4", pc_plus4, C_RESET_PC + 32'd4);
        #1;
        imem_ready = 1'b0;
        rst_n = 1'b1;

        // Directed walk through the reference scenarios.
        drive(1, 32'h3C01_1234, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 0, 0,0,0,0,0,0, 32'd0);
        drive(1, 32'h0000_0000, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 0,0,0,0,0,0, 32'd0);
        drive(1, 32'h1000_FFFE, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 0,0,0,1,0,1, 32'd0);
        drive(1, 32'h1000_FFFE, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 0,0,0,1,0,0, 32'd0);
        drive(1, 32'h0000_0020, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 1,0,0,0,0,0, 32'h4000_0010);
        drive(1, 32'h0C00_0040, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 0,0,1,0,0,0, 32'd0);
        drive(1, 32'h0000_0000, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 1,0,0,0,0,0, 32'hFFFF_FFFC);
        drive(1, 32'h0000_0000, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 0,0,0,0,0,0, 32'd0);
        drive(1, 32'h0800_0001, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 1,1,0,0,0,0, 32'h0000_0203);
        drive(1, 32'h0000_0000, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 1, 0,0,0,0,0,0, 32'd0);
        drive(1, 32'h1111_2222, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 0, 0,0,0,0,0,0, 32'd0);
        drive(0, 32'd0, 0, 0,0,0,0,0,0, 32'd0);
        reset_pulse();

        // Randomized traffic, with one reset landing at an arbitrary point.
        for (int i = 0; i < 400; i++) begin
            bit          jr;
            logic [31:0] rs;
            jr = ($urandom_range(0, 15) == 0);
            rs = $urandom;
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) != 0,
                  jr, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) != 0, rs);
            if (i == 200) reset_pulse();
        end

        drive(0, 32'd0, 0, 0,0,0,0,0,0, 32'd0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
